// File: rtl/regfile_rename_pkg.sv
// Shared defaults and helpers for the register file / rename table slice.
package regfile_rename_pkg;
  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREG  = 32;
  localparam int DEF_ROB_W = 3;

  // Register-id width; never collapses to zero bits for tiny files.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/regfile_rename_if.sv
// Decode/issue + ROB side bus of the register file: reads, ROB queries, renames, commits.
interface regfile_rename_if
  import regfile_rename_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREG  = DEF_NREG,
  parameter int ROB_W = DEF_ROB_W,
  parameter int NRD   = 2,
  parameter int NREN  = 1,
  parameter int NCMT  = 1
) ();
  localparam int RID_W = id_width(NREG);

  logic                             rdy_in;
  logic                             flush_in;
  logic [NRD-1:0][RID_W-1:0]        rd_id;
  logic [NRD-1:0][XLEN-1:0]         rd_val;
  logic [NRD-1:0]                   rd_dep;
  logic [NRD-1:0][ROB_W-1:0]        rd_tag;
  logic [NRD-1:0][ROB_W-1:0]        rob_qtag;
  logic [NRD-1:0]                   rob_qready;
  logic [NRD-1:0][XLEN-1:0]         rob_qval;
  logic [NREN-1:0]                  ren_en;
  logic [NREN-1:0][RID_W-1:0]       ren_id;
  logic [NREN-1:0][ROB_W-1:0]       ren_tag;
  logic [NCMT-1:0]                  cmt_en;
  logic [NCMT-1:0][RID_W-1:0]       cmt_id;
  logic [NCMT-1:0][XLEN-1:0]        cmt_val;
  logic [NCMT-1:0][ROB_W-1:0]       cmt_tag;

  modport master (
    output rdy_in, flush_in, rd_id, rob_qready, rob_qval,
           ren_en, ren_id, ren_tag, cmt_en, cmt_id, cmt_val, cmt_tag,
    input  rd_val, rd_dep, rd_tag, rob_qtag
  );

  modport slave (
    input  rdy_in, flush_in, rd_id, rob_qready, rob_qval,
           ren_en, ren_id, ren_tag, cmt_en, cmt_id, cmt_val, cmt_tag,
    output rd_val, rd_dep, rd_tag, rob_qtag
  );
endinterface

// File: rtl/regfile_rd_port.sv
// One operand lookup: youngest same-cycle rename first, then the table, then the ROB query.
module regfile_rd_port
  import regfile_rename_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREG  = DEF_NREG,
  parameter int ROB_W = DEF_ROB_W,
  parameter int NREN  = 1,
  parameter int RID_W = id_width(NREG)
) (
  input  logic [RID_W-1:0]            rd_id,
  input  logic [NREN-1:0]             ren_en,
  input  logic [NREN-1:0][RID_W-1:0]  ren_id,
  input  logic [NREN-1:0][ROB_W-1:0]  ren_tag,
  input  logic [NREG-1:0][XLEN-1:0]   table_val,
  input  logic [NREG-1:0]             table_busy,
  input  logic [NREG-1:0][ROB_W-1:0]  table_tag,
  input  logic                        rob_qready,
  input  logic [XLEN-1:0]             rob_qval,
  output logic [XLEN-1:0]             rd_val,
  output logic                        rd_dep,
  output logic [ROB_W-1:0]            rd_tag,
  output logic [ROB_W-1:0]            rob_qtag
);
  logic             pend;
  logic [ROB_W-1:0] pend_tag;
  logic             busy;
  logic [ROB_W-1:0] eff_tag;

  // Later ports overwrite earlier ones, so the youngest matching rename wins.
  always_comb begin
    pend     = 1'b0;
    pend_tag = '0;
    for (int k = 0; k < NREN; k++) begin
      if (ren_en[k] && ren_id[k] == rd_id && rd_id != '0) begin
        pend     = 1'b1;
        pend_tag = ren_tag[k];
      end
    end
  end

  assign busy    = pend | table_busy[rd_id];
  assign eff_tag = pend ? pend_tag : (table_busy[rd_id] ? table_tag[rd_id] : '0);

  assign rd_tag   = eff_tag;
  assign rob_qtag = eff_tag;
  assign rd_dep   = busy & ~rob_qready;
  assign rd_val   = busy ? rob_qval : table_val[rd_id];
endmodule

// File: rtl/regfile_rename.sv
// Multi-ported architectural register file with rename table; x0 is never written.
module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREG  = DEF_NREG,
  parameter int ROB_W = DEF_ROB_W,
  parameter int NRD   = 2,
  parameter int NREN  = 1,
  parameter int NCMT  = 1
) (
  input  logic           clk_in,
  input  logic           rst_in,
  regfile_rename_if.slave bus
);
  localparam int RID_W = id_width(NREG);

  logic [NREG-1:0][XLEN-1:0]  val_reg,  val_next;
  logic [NREG-1:0]            busy_reg, busy_next;
  logic [NREG-1:0][ROB_W-1:0] tag_reg,  tag_next;

  always_comb begin
    logic             ren_hit;
    logic             cmt_clr;
    logic [ROB_W-1:0] ren_t;
    val_next  = val_reg;
    busy_next = busy_reg;
    tag_next  = tag_reg;
    ren_hit   = 1'b0;
    cmt_clr   = 1'b0;
    ren_t     = '0;
    for (int e = 1; e < NREG; e++) begin
      ren_hit = 1'b0;
      cmt_clr = 1'b0;
      ren_t   = '0;
      // Highest commit port writes last; clears compare against the pre-edge tag.
      for (int j = 0; j < NCMT; j++) begin
        if (bus.cmt_en[j] && bus.cmt_id[j] == RID_W'(e)) begin
          val_next[e] = bus.cmt_val[j];
          if (tag_reg[e] == bus.cmt_tag[j]) cmt_clr = 1'b1;
        end
      end
      for (int k = 0; k < NREN; k++) begin
        if (bus.ren_en[k] && bus.ren_id[k] == RID_W'(e)) begin
          ren_hit = 1'b1;
          ren_t   = bus.ren_tag[k];
        end
      end
      // Flush beats rename beats commit-clear; the value write survives all of them.
      if (bus.flush_in) begin
        busy_next[e] = 1'b0;
        tag_next[e]  = '0;
      end else if (ren_hit) begin
        busy_next[e] = 1'b1;
        tag_next[e]  = ren_t;
      end else if (cmt_clr) begin
        busy_next[e] = 1'b0;
        tag_next[e]  = '0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      val_reg  <= '0;
      busy_reg <= '0;
      tag_reg  <= '0;
    end else if (bus.rdy_in) begin
      val_reg  <= val_next;
      busy_reg <= busy_next;
      tag_reg  <= tag_next;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    regfile_rd_port #(
      .XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NREN(NREN), .RID_W(RID_W)
    ) u_port (
      .rd_id      (bus.rd_id[gi]),
      .ren_en     (bus.ren_en),
      .ren_id     (bus.ren_id),
      .ren_tag    (bus.ren_tag),
      .table_val  (val_reg),
      .table_busy (busy_reg),
      .table_tag  (tag_reg),
      .rob_qready (bus.rob_qready[gi]),
      .rob_qval   (bus.rob_qval[gi]),
      .rd_val     (bus.rd_val[gi]),
      .rd_dep     (bus.rd_dep[gi]),
      .rd_tag     (bus.rd_tag[gi]),
      .rob_qtag   (bus.rob_qtag[gi])
    );
  end
endmodule

// File: tb/tb_regfile_rename.sv
// Bench for regfile_rename: directed vector table, corner sequences, random run vs. a table model.
module tb_regfile_rename;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int RID_W = 5;
  localparam int ROB_W = 3;
  localparam int NRD   = 2;
  localparam int NREN  = 2;
  localparam int NCMT  = 2;
  localparam int NVEC  = 17;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic clk_run = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always begin
    #5;
    if (clk_run) clk_in = ~clk_in;
  end

  regfile_rename_if #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W),
                      .NRD(NRD), .NREN(NREN), .NCMT(NCMT)) bus ();

  regfile_rename #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W),
                   .NRD(NRD), .NREN(NREN), .NCMT(NCMT)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  // Reference state: what each architectural register holds and who will produce it.
  logic [XLEN-1:0]  m_val  [NREG];
  logic             m_busy [NREG];
  logic [ROB_W-1:0] m_tag  [NREG];

  function automatic void model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
    end
  endfunction

  function automatic logic renamed_now(input int r);
    for (int k = 0; k < NREN; k++)
      if (bus.ren_en[k] && int'(bus.ren_id[k]) == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_edge();
    logic [ROB_W-1:0] old_tag [NREG];
    if (!bus.rdy_in) return;
    for (int r = 0; r < NREG; r++) old_tag[r] = m_tag[r];
    for (int j = 0; j < NCMT; j++) begin
      int r = int'(bus.cmt_id[j]);
      if (bus.cmt_en[j] && r != 0) begin
        m_val[r] = bus.cmt_val[j];
        if (old_tag[r] == bus.cmt_tag[j] && !renamed_now(r)) begin
          m_busy[r] = 1'b0; m_tag[r] = '0;
        end
      end
    end
    for (int k = 0; k < NREN; k++) begin
      int r = int'(bus.ren_id[k]);
      if (bus.ren_en[k] && r != 0) begin
        m_busy[r] = 1'b1; m_tag[r] = bus.ren_tag[k];
      end
    end
    if (bus.flush_in)
      for (int r = 0; r < NREG; r++) begin
        m_busy[r] = 1'b0; m_tag[r] = '0;
      end
  endfunction

  function automatic void model_rd(input int p, output logic [XLEN-1:0] v,
                                   output logic d, output logic [ROB_W-1:0] t);
    int r = int'(bus.rd_id[p]);
    logic b = (r != 0) && m_busy[r];
    logic [ROB_W-1:0] tg = m_tag[r];
    if (r != 0 && renamed_now(r))
      for (int k = 0; k < NREN; k++)
        if (bus.ren_en[k] && int'(bus.ren_id[k]) == r) begin b = 1'b1; tg = bus.ren_tag[k]; end
    if (b) begin d = !bus.rob_qready[p]; v = bus.rob_qval[p]; t = tg; end
    else   begin d = 1'b0; v = (r == 0) ? '0 : m_val[r]; t = '0; end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_port(input int p, input string name, input logic [XLEN-1:0] ev,
                          input logic ed, input logic [ROB_W-1:0] et);
    chk($sformatf("%s p%0d rd_val", name, p), bus.rd_val[p], ev);
    chk($sformatf("%s p%0d rd_dep", name, p), 32'(bus.rd_dep[p]), 32'(ed));
    chk($sformatf("%s p%0d rd_tag", name, p), 32'(bus.rd_tag[p]), 32'(et));
    chk($sformatf("%s p%0d rob_qtag", name, p), 32'(bus.rob_qtag[p]), 32'(et));
  endtask

  task automatic idle();
    bus.rdy_in = 1'b1; bus.flush_in = 1'b0;
    bus.rd_id = '0; bus.rob_qready = '0; bus.rob_qval = '0;
    bus.ren_en = '0; bus.ren_id = '0; bus.ren_tag = '0;
    bus.cmt_en = '0; bus.cmt_id = '0; bus.cmt_val = '0; bus.cmt_tag = '0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
  endtask

  typedef struct {
    logic             ren_en;  logic [RID_W-1:0] ren_id;  logic [ROB_W-1:0] ren_tag;
    logic             cmt_en;  logic [RID_W-1:0] cmt_id;  logic [XLEN-1:0]  cmt_val;
    logic [ROB_W-1:0] cmt_tag; logic             flush;
    logic [RID_W-1:0] rd_id;   logic             qready;  logic [XLEN-1:0]  qval;
    logic [XLEN-1:0]  exp_val; logic             exp_dep; logic [ROB_W-1:0] exp_tag;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    logic [XLEN-1:0]  ev;
    logic             ed;
    logic [ROB_W-1:0] et;

    //            ren        commit                   fl   read             expected
    vecs[0]  = '{0,0,0, 0,0,32'h0,0,       0, 5,0,32'h0,   32'h0,0,0};
    vecs[1]  = '{0,0,0, 1,5,32'hDEAD,2,    0, 5,0,32'h0,   32'h0,0,0};
    vecs[2]  = '{0,0,0, 0,0,32'h0,0,       0, 5,0,32'h0,   32'hDEAD,0,0};
    vecs[3]  = '{1,3,4, 0,0,32'h0,0,       0, 3,0,32'h0,   32'h0,1,4};
    vecs[4]  = '{0,0,0, 0,0,32'h0,0,       0, 3,0,32'h0,   32'h0,1,4};
    vecs[5]  = '{0,0,0, 0,0,32'h0,0,       0, 3,1,32'h11,  32'h11,0,4};
    vecs[6]  = '{1,3,6, 1,3,32'h33,4,      0, 3,0,32'h0,   32'h0,1,6};
    vecs[7]  = '{0,0,0, 1,3,32'h44,4,      0, 3,1,32'h77,  32'h77,0,6};
    vecs[8]  = '{0,0,0, 0,0,32'h0,0,       0, 3,0,32'h0,   32'h0,1,6};
    vecs[9]  = '{0,0,0, 1,3,32'h66,6,      0, 3,0,32'h0,   32'h0,1,6};
    vecs[10] = '{0,0,0, 0,0,32'h0,0,       0, 3,0,32'h0,   32'h66,0,0};
    vecs[11] = '{1,2,3, 0,0,32'h0,0,       0, 2,0,32'h0,   32'h0,1,3};
    vecs[12] = '{1,9,1, 1,2,32'h42,5,      1, 2,0,32'h0,   32'h0,1,3};
    vecs[13] = '{0,0,0, 0,0,32'h0,0,       0, 2,0,32'h0,   32'h42,0,0};
    vecs[14] = '{0,0,0, 0,0,32'h0,0,       0, 9,0,32'h0,   32'h0,0,0};
    vecs[15] = '{1,0,7, 0,0,32'h0,0,       0, 0,0,32'h0,   32'h0,0,0};
    vecs[16] = '{0,0,0, 0,0,32'h0,0,       0, 0,0,32'h0,   32'h0,0,0};

    idle();
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    tick();  // first edge after reset release carries no traffic

    for (int i = 0; i < NVEC; i++) begin
      idle();
      bus.ren_en[0] = vecs[i].ren_en; bus.ren_id[0] = vecs[i].ren_id; bus.ren_tag[0] = vecs[i].ren_tag;
      bus.cmt_en[0] = vecs[i].cmt_en; bus.cmt_id[0] = vecs[i].cmt_id;
      bus.cmt_val[0] = vecs[i].cmt_val; bus.cmt_tag[0] = vecs[i].cmt_tag;
      bus.flush_in = vecs[i].flush;
      for (int p = 0; p < NRD; p++) begin
        bus.rd_id[p] = vecs[i].rd_id; bus.rob_qready[p] = vecs[i].qready; bus.rob_qval[p] = vecs[i].qval;
      end
      #1;
      for (int p = 0; p < NRD; p++)
        chk_port(p, $sformatf("vec%0d", i), vecs[i].exp_val, vecs[i].exp_dep, vecs[i].exp_tag);
      $display("[TB] vec %0d rd x%0d val=%0h dep=%0d tag=%0d", i, vecs[i].rd_id,
               bus.rd_val[0], bus.rd_dep[0], bus.rd_tag[0]);
      tick();
    end

    // Two renames of x7 in one cycle: port 1 is younger and wins.
    idle();
    bus.ren_en = 2'b11; bus.ren_id[0] = 7; bus.ren_tag[0] = 1; bus.ren_id[1] = 7; bus.ren_tag[1] = 5;
    bus.rd_id[0] = 7; bus.rd_id[1] = 7;
    #1; chk_port(0, "dual_ren_bypass", 32'h0, 1'b1, 3'd5);
    $display("[TB] dual rename x7 same-cycle tag=%0d", bus.rd_tag[0]);
    tick();
    idle(); bus.rd_id[0] = 7;
    #1; chk_port(0, "dual_ren_table", 32'h0, 1'b1, 3'd5);
    $display("[TB] dual rename x7 table tag=%0d", bus.rd_tag[0]);
    tick();

    // Flush, rename and commit to x4 together: value lands, entry idle.
    idle();
    bus.flush_in = 1'b1; bus.ren_en[0] = 1'b1; bus.ren_id[0] = 4; bus.ren_tag[0] = 2;
    bus.cmt_en[0] = 1'b1; bus.cmt_id[0] = 4; bus.cmt_val[0] = 32'h99; bus.cmt_tag[0] = 0;
    tick();
    idle(); bus.rd_id[0] = 4;
    #1; chk_port(0, "flush_ren_cmt", 32'h99, 1'b0, 3'd0);
    $display("[TB] flush+rename+commit x4 val=%0h dep=%0d", bus.rd_val[0], bus.rd_dep[0]);
    tick();

    // rdy_in low: bypass still visible, but no state change at the edge.
    idle();
    bus.rdy_in = 1'b0; bus.ren_en[0] = 1'b1; bus.ren_id[0] = 6; bus.ren_tag[0] = 3;
    bus.cmt_en[0] = 1'b1; bus.cmt_id[0] = 5; bus.cmt_val[0] = 32'h12; bus.cmt_tag[0] = 0;
    bus.rd_id[0] = 6;
    #1; chk_port(0, "stall_bypass", 32'h0, 1'b1, 3'd3);
    tick();
    idle(); bus.rd_id[0] = 6; bus.rd_id[1] = 5;
    #1;
    chk_port(0, "stall_no_ren", 32'h0, 1'b0, 3'd0);
    chk_port(1, "stall_no_cmt", 32'hDEAD, 1'b0, 3'd0);
    $display("[TB] stall x6 dep=%0d x5 val=%0h", bus.rd_dep[0], bus.rd_val[1]);
    tick();

    // Two commits to x8 in one cycle: port 1 value wins.
    idle();
    bus.cmt_en = 2'b11; bus.cmt_id[0] = 8; bus.cmt_val[0] = 32'hA; bus.cmt_id[1] = 8; bus.cmt_val[1] = 32'hB;
    tick();
    idle(); bus.rd_id[0] = 8;
    #1; chk_port(0, "dual_cmt", 32'hB, 1'b0, 3'd0);
    $display("[TB] dual commit x8 val=%0h", bus.rd_val[0]);
    tick();

    // Asynchronous reset with the clock parked low.
    clk_run = 1'b0;
    idle(); bus.rd_id[0] = 5; bus.rd_id[1] = 7;
    #2; rst_in = 1'b0;
    #1;
    chk_port(0, "async_rst_x5", 32'h0, 1'b0, 3'd0);
    chk_port(1, "async_rst_x7", 32'h0, 1'b0, 3'd0);
    $display("[TB] async reset x5 val=%0h x7 dep=%0d", bus.rd_val[0], bus.rd_dep[1]);
    model_reset();
    #3; rst_in = 1'b1;
    #1; clk_run = 1'b1;
    tick();

    // Random traffic on a small id range so ports collide often.
    for (int c = 0; c < 300; c++) begin
      idle();
      bus.rdy_in   = ($urandom_range(0, 9) != 0);
      bus.flush_in = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < NREN; k++) begin
        bus.ren_en[k]  = 1'($urandom_range(0, 1));
        bus.ren_id[k]  = RID_W'($urandom_range(0, 7));
        bus.ren_tag[k] = ROB_W'($urandom);
      end
      for (int j = 0; j < NCMT; j++) begin
        bus.cmt_en[j]  = 1'($urandom_range(0, 1));
        bus.cmt_id[j]  = RID_W'($urandom_range(0, 7));
        bus.cmt_val[j] = $urandom;
        bus.cmt_tag[j] = $urandom_range(0, 1) ? m_tag[int'(bus.cmt_id[j])] : ROB_W'($urandom);
      end
      for (int p = 0; p < NRD; p++) begin
        bus.rd_id[p]      = RID_W'($urandom_range(0, 7));
        bus.rob_qready[p] = 1'($urandom_range(0, 1));
        bus.rob_qval[p]   = $urandom;
      end
      #1;
      for (int p = 0; p < NRD; p++) begin
        model_rd(p, ev, ed, et);
        chk_port(p, $sformatf("rnd%0d", c), ev, ed, et);
      end
      $display("[TB] rnd %0d rd=x%0d/x%0d ren=%b cmt=%b flush=%0d rdy=%0d", c,
               bus.rd_id[0], bus.rd_id[1], bus.ren_en, bus.cmt_en, bus.flush_in, bus.rdy_in);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
